// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between two requesters and the ALU arbiter.
// The master side is the requester pair. It drives valid, payload and response-ready.
// The slave side is the arbiter. It drives request-ready, response-valid and the shared result.
interface alu_arbiter_if #(
  parameter int N = 32
);
  // Request port 0
  logic         req0_valid;
  logic         req0_ready;
  logic [N-1:0] req0_a;
  logic [N-1:0] req0_b;
  logic [2:0]   req0_op;

  // Request port 1
  logic         req1_valid;
  logic         req1_ready;
  logic [N-1:0] req1_a;
  logic [N-1:0] req1_b;
  logic [2:0]   req1_op;

  // Response ports; result and overflow are shared by both
  logic         rsp0_valid;
  logic         rsp0_ready;
  logic         rsp1_valid;
  logic         rsp1_ready;
  logic [N-1:0] rsp_c;
  logic         rsp_ov;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_c, rsp_ov
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_c, rsp_ov
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external N-bit ALU between two requesters and grants round-robin on a tie.
// Latency: 2 cycles from request handshake to response valid. Peak throughput is one op per 3 cycles.
// Backpressure: the response is held until its port takes it, and both request ports are stalled meanwhile.
//
// Ports:
//   clk, rst           rising-edge clock; asynchronous active-high reset
//   bus (slave)        two request ports (valid/ready, a, b, op) and two response ports (valid/ready)
//                      with a shared rsp_c / rsp_ov
//   alu_a_o/alu_b_o    registered operands to the ALU
//   alu_op_o           registered opcode to the ALU
//   alu_c_i/alu_ov_i   ALU result and signed-overflow flag
//   busy_o             high while an operation is executing or waiting to be returned
//   grant_id_o         requester owning the current or last operation
module alu_arbiter #(
  parameter int N = 32
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus,
  output logic [N-1:0]  alu_a_o,
  output logic [N-1:0]  alu_b_o,
  output logic [2:0]    alu_op_o,
  input  logic [N-1:0]  alu_c_i,
  input  logic          alu_ov_i,
  output logic          busy_o,
  output logic          grant_id_o
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t       state_q,      state_d;
  logic         last_grant_q, last_grant_d;
  logic         grant_id_q,   grant_id_d;
  logic [N-1:0] alu_a_q,      alu_a_d;
  logic [N-1:0] alu_b_q,      alu_b_d;
  logic [2:0]   alu_op_q,     alu_op_d;
  logic [N-1:0] rsp_c_q,      rsp_c_d;
  logic         rsp_ov_q,     rsp_ov_d;
  logic         rsp0_vld_q,   rsp0_vld_d;
  logic         rsp1_vld_q,   rsp1_vld_d;
  logic         busy_q,       busy_d;

  // Grant: a lone requester wins outright; on a tie the port that did not
  // own the last completed operation wins. At most one of gnt0/gnt1 is high.
  logic gnt0, gnt1;
  assign gnt0 = bus.req0_valid & (~bus.req1_valid |  last_grant_q);
  assign gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);

  // Ready is combinational from the valids and only offered in IDLE.
  // It is also masked during reset so no handshake can appear to occur while the flops are held.
  logic idle;
  assign idle = (state_q == S_IDLE) & ~rst;
  assign bus.req0_ready = idle & gnt0;
  assign bus.req1_ready = idle & gnt1;

  // Payload of whichever port is granted this cycle.
  logic [N-1:0] sel_a, sel_b;
  logic [2:0]   sel_op;
  assign sel_a  = gnt1 ? bus.req1_a  : bus.req0_a;
  assign sel_b  = gnt1 ? bus.req1_b  : bus.req0_b;
  assign sel_op = gnt1 ? bus.req1_op : bus.req0_op;

  // Only add and subtract can overflow. The ALU's flag is ignored for logic
  // ops and for reserved opcodes, whatever the ALU drives.
  logic ov_qual;
  assign ov_qual = ((alu_op_q == OP_ADD) | (alu_op_q == OP_SUB)) & alu_ov_i;

  // Response is taken only by the port that owns it.
  logic rsp_take;
  assign rsp_take = grant_id_q ? bus.rsp1_ready : bus.rsp0_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_c_d      = rsp_c_q;
    rsp_ov_d     = rsp_ov_q;
    rsp0_vld_d   = rsp0_vld_q;
    rsp1_vld_d   = rsp1_vld_q;
    busy_d       = busy_q;

    unique case (state_q)
      S_IDLE: begin
        // A grant in IDLE is a handshake, because ready equals the grant here.
        if (gnt0 | gnt1) begin
          grant_id_d = gnt1;
          alu_a_d    = sel_a;
          alu_b_d    = sel_b;
          alu_op_d   = sel_op;
          busy_d     = 1'b1;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        // The ALU inputs have been stable for a full cycle, so capture its output.
        rsp_c_d    = alu_c_i;
        rsp_ov_d   = ov_qual;
        rsp0_vld_d = ~grant_id_q;
        rsp1_vld_d =  grant_id_q;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (rsp_take) begin
          rsp0_vld_d   = 1'b0;
          rsp1_vld_d   = 1'b0;
          busy_d       = 1'b0;
          last_grant_d = grant_id_q;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;   // port 0 wins the first tie after reset
      grant_id_q   <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= OP_ADD;
      rsp_c_q      <= '0;
      rsp_ov_q     <= 1'b0;
      rsp0_vld_q   <= 1'b0;
      rsp1_vld_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_c_q      <= rsp_c_d;
      rsp_ov_q     <= rsp_ov_d;
      rsp0_vld_q   <= rsp0_vld_d;
      rsp1_vld_q   <= rsp1_vld_d;
      busy_q       <= busy_d;
    end
  end

  assign alu_a_o        = alu_a_q;
  assign alu_b_o        = alu_b_q;
  assign alu_op_o       = alu_op_q;
  assign bus.rsp_c      = rsp_c_q;
  assign bus.rsp_ov     = rsp_ov_q;
  assign bus.rsp0_valid = rsp0_vld_q;
  assign bus.rsp1_valid = rsp1_vld_q;
  assign busy_o         = busy_q;
  assign grant_id_o     = grant_id_q;

endmodule
